// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: streams a program image into instruction
// memory (LOAD), then drives the fetch PC (RUN) until halt (HALT).
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   LoadValid/Data/Done   program loader handshake; LoadReady high in LOAD
//   MemWrEn/WrData/Addr   instruction memory write strobe, data, byte addr
//   Stall, Redirect,      downstream hazard, taken branch/jump and its
//   RedirectTarget, Halt  target, halt seen by decode
//   PC, PCPlus4           fetch byte address and its link value
//   InstrValid, Halted    valid fetch this cycle, controller halted
//   FetchCount            valid fetches since reset
module instruction_fetch_controller #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadValid,
  input  logic [31:0] LoadData,
  input  logic        LoadDone,
  output logic        LoadReady,
  output logic        MemWrEn,
  output logic [31:0] MemWrData,
  output logic [31:0] MemAddr,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    HALT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] load_cnt_nx;
  logic [31:0]       pc;
  logic [31:0]       pc_nx;
  logic [31:0]       fcnt;
  logic [31:0]       fcnt_nx;
  logic              full;

  // Last memory word is being pointed at; writing it ends the load.
  assign full = &load_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= LOAD;
      load_cnt <= '0;
      pc       <= RESET_PC;
      fcnt     <= '0;
    end else begin
      state    <= state_nx;
      load_cnt <= load_cnt_nx;
      pc       <= pc_nx;
      fcnt     <= fcnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    load_cnt_nx = load_cnt;
    pc_nx       = pc;
    fcnt_nx     = fcnt;
    LoadReady   = 1'b0;
    MemWrEn     = 1'b0;
    MemAddr     = pc;
    InstrValid  = 1'b0;
    Halted      = 1'b0;
    unique case (state)
      LOAD: begin
        LoadReady = 1'b1;
        MemWrEn   = LoadValid;
        MemAddr   = {{(30-ADDR_W){1'b0}}, load_cnt, 2'b00};
        pc_nx     = RESET_PC;
        // Counter saturates at the last word; the load is over by then.
        if (LoadValid && !full)
          load_cnt_nx = load_cnt + ADDR_W'(1);
        if (LoadDone || (LoadValid && full))
          state_nx = RUN;
      end
      RUN: begin
        InstrValid = ~Stall;
        if (!Stall)
          fcnt_nx = fcnt + 32'd1;
        // Halt beats redirect; redirect beats stall.
        if (Halt)
          state_nx = HALT;
        else if (Redirect)
          pc_nx = {RedirectTarget[31:2], 2'b00};
        else if (!Stall)
          pc_nx = pc + 32'd4;
      end
      HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_nx = LOAD;
      end
    endcase
  end

  assign MemWrData  = LoadData;
  assign PC         = pc;
  assign PCPlus4    = pc + 32'd4;
  assign FetchCount = fcnt;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller: load, run, stall,
// redirect, halt, reset and memory-full behaviour.
module tb_instruction_fetch_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LoadValid;
  logic [31:0] LoadData;
  logic        LoadDone;
  logic        LoadReady;
  logic        MemWrEn;
  logic [31:0] MemWrData;
  logic [31:0] MemAddr;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        Halt;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        Halted;
  logic [31:0] FetchCount;

  logic        Reset2;
  logic        LoadValid2;
  logic        LoadDone2;
  logic        LoadReady2;
  logic        MemWrEn2;
  logic [31:0] MemWrData2;
  logic [31:0] MemAddr2;
  logic [31:0] PC2;
  logic [31:0] PCPlus42;
  logic        InstrValid2;
  logic        Halted2;
  logic [31:0] FetchCount2;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] words [4] = '{
    32'h2008_0005, 32'h0C00_0004,
    32'h0000_0000, 32'hFFFF_FFFF
  };

  always #5 Clk = ~Clk;

  instruction_fetch_controller dut (
    .Clk(Clk), .Reset(Reset),
    .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadDone(LoadDone), .LoadReady(LoadReady),
    .MemWrEn(MemWrEn), .MemWrData(MemWrData),
    .MemAddr(MemAddr), .Stall(Stall),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .Halt(Halt), .PC(PC), .PCPlus4(PCPlus4),
    .InstrValid(InstrValid), .Halted(Halted),
    .FetchCount(FetchCount)
  );

  instruction_fetch_controller #(.ADDR_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset2),
    .LoadValid(LoadValid2), .LoadData(LoadData),
    .LoadDone(LoadDone2), .LoadReady(LoadReady2),
    .MemWrEn(MemWrEn2), .MemWrData(MemWrData2),
    .MemAddr(MemAddr2), .Stall(Stall),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .Halt(Halt), .PC(PC2), .PCPlus4(PCPlus42),
    .InstrValid(InstrValid2), .Halted(Halted2),
    .FetchCount(FetchCount2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    Reset2 = 1'b1;
    LoadValid = 1'b0;
    LoadValid2 = 1'b0;
    LoadData = '0;
    LoadDone = 1'b0;
    LoadDone2 = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = '0;
    Halt = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_loadready", LoadReady, 1);
    chk("rst_memwren", MemWrEn, 0);
    chk("rst_instrvalid", InstrValid, 0);
    chk("rst_halted", Halted, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_pc", PC, 0);
    chk("rst_fcnt", FetchCount, 0);

    for (int i = 0; i < 4; i++) begin
      LoadValid = 1'b1;
      LoadData = words[i];
      LoadDone = (i == 3);
      #1;
      chk("ld_wren", MemWrEn, 1);
      chk("ld_addr", MemAddr, 32'(i * 4));
      chk("ld_data", MemWrData, words[i]);
      tick();
    end
    LoadValid = 1'b1;
    LoadDone = 1'b0;
    #1;
    chk("run_valid", InstrValid, 1);
    chk("run_pc0", PC, 0);
    chk("run_memaddr", MemAddr, 0);
    chk("run_loadready", LoadReady, 0);
    chk("run_wren_ign", MemWrEn, 0);
    LoadValid = 1'b0;
    tick();
    chk("run_pc4", PC, 32'h4);
    chk("run_fc1", FetchCount, 1);

    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_pc", PC, 32'h4);
      chk("stl_valid", InstrValid, 0);
      tick();
    end
    Stall = 1'b0;
    #1;
    chk("stl_release_pc", PC, 32'h4);
    chk("stl_release_v", InstrValid, 1);
    tick();
    chk("stl_pc8", PC, 32'h8);
    chk("stl_fc2", FetchCount, 2);

    Stall = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 32'h0000_0013;
    #1;
    chk("redir_valid", InstrValid, 0);
    tick();
    Stall = 1'b0;
    Redirect = 1'b0;
    chk("redir_pc", PC, 32'h10);
    chk("redir_fc", FetchCount, 2);
    chk("redir_pcp4", PCPlus4, 32'h14);
    tick();
    chk("seq_pc14", PC, 32'h14);
    chk("seq_fc3", FetchCount, 3);

    Redirect = 1'b1;
    RedirectTarget = 32'h0000_000C;
    tick();
    Redirect = 1'b0;
    chk("to_c_pc", PC, 32'hC);
    chk("to_c_fc", FetchCount, 4);
    Halt = 1'b1;
    #1;
    chk("halt_valid", InstrValid, 1);
    tick();
    Halt = 1'b0;
    Redirect = 1'b1;
    RedirectTarget = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hlt_halted", Halted, 1);
      chk("hlt_pc", PC, 32'hC);
      chk("hlt_valid", InstrValid, 0);
      chk("hlt_fc", FetchCount, 5);
      chk("hlt_memaddr", MemAddr, 32'hC);
      tick();
    end
    Redirect = 1'b0;

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("hrst_loadready", LoadReady, 1);
    chk("hrst_halted", Halted, 0);
    chk("hrst_pc", PC, 0);
    chk("hrst_fc", FetchCount, 0);

    LoadValid = 1'b1;
    tick();
    tick();
    chk("mid_addr8", MemAddr, 32'h8);
    LoadValid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    LoadValid = 1'b1;
    #1;
    chk("mid_addr0", MemAddr, 0);
    chk("mid_wren", MemWrEn, 1);
    tick();
    LoadValid = 1'b0;
    LoadDone = 1'b1;
    tick();
    LoadDone = 1'b0;
    chk("wrap_run_pc", PC, 0);
    chk("wrap_run_v", InstrValid, 1);
    Redirect = 1'b1;
    RedirectTarget = 32'hFFFF_FFFE;
    tick();
    Redirect = 1'b0;
    chk("wrap_pc_top", PC, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4, 0);
    tick();
    chk("wrap_pc0", PC, 0);
    chk("wrap_fc", FetchCount, 2);

    tick();
    Reset2 = 1'b0;
    #1;
    chk("f_rst_ready", LoadReady2, 1);
    for (int i = 0; i < 4; i++) begin
      LoadValid2 = 1'b1;
      LoadData = words[i];
      #1;
      chk("f_wren", MemWrEn2, 1);
      chk("f_addr", MemAddr2, 32'(i * 4));
      tick();
    end
    #1;
    chk("f_run_valid", InstrValid2, 1);
    chk("f_run_pc", PC2, 0);
    chk("f_5th_wren", MemWrEn2, 0);
    chk("f_5th_ready", LoadReady2, 0);
    tick();
    LoadValid2 = 1'b0;
    chk("f_pc4", PC2, 32'h4);
    chk("f_fc", FetchCount2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
# instruction_fetch_controller

Sequences the word-addressed instruction memory for the single-cycle MIPS core. After reset it owns the memory's write port and streams a program image into it from an external loader. It then releases the core and drives the fetch address (PC) every cycle, handling stalls, branch/jump redirects and halt. It sits between the loader/testbench, the instruction memory and the decode/branch logic.

## Interface

- ADDR_W, 10, width of the instruction-memory word index (depth 2^ADDR_W words)
- RESET_PC, 32'h00000000, PC value on entry to RUN; bits [1:0] must be zero
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge
- LoadValid  in  1  loader presents a word on LoadData
- LoadData  in  32  program word to write
- LoadDone  in  1  loader has finished; end load phase
- LoadReady  out  1  controller accepts load words (high only in LOAD)
- MemWrEn  out  1  write strobe to instruction memory
- MemWrData  out  32  write data to instruction memory (= LoadData)
- MemAddr  out  32  byte address to instruction memory
- Stall  in  1  hold PC this cycle (hazard from downstream)
- Redirect  in  1  branch/jump taken this cycle
- RedirectTarget  in  32  byte address of taken target
- Halt  in  1  decode saw the halt instruction
- PC  out  32  current fetch byte address
- PCPlus4  out  32  PC + 4 (link value for jal)
- InstrValid  out  1  MemAddr/PC is a valid fetch this cycle
- Halted  out  1  controller is in HALT
- FetchCount  out  32  number of valid fetches since reset

## Operation

- States: LOAD, RUN, HALT. Reset forces LOAD from any state, including mid-load and mid-run.
- Reset values: state LOAD, LoadCount 0, PC RESET_PC, FetchCount 0. Resulting outputs: LoadReady 1, MemWrEn 0, InstrValid 0, Halted 0, MemAddr 0.
- LOAD:
  - MemAddr = {LoadCount, 2'b00} zero-extended to 32 bits.
  - MemWrEn = LoadValid.
  - On each edge with LoadValid=1, LoadCount increments by 1.
- LOAD exit:
  - LoadDone=1 moves to RUN at the next edge; a word presented in the same cycle is still written.
  - Writing word 2^ADDR_W-1 (memory full) also moves to RUN; LoadCount does not wrap into a second pass.
  - On entry to RUN, PC = RESET_PC.
- RUN:
  - MemAddr = PC; MemWrEn = 0; LoadReady = 0; LoadValid and LoadDone are ignored.
  - InstrValid = ~Stall.
- Next-PC priority in RUN:
  - Halt → HALT with PC held.
  - Otherwise Redirect → {RedirectTarget[31:2], 2'b00}. Redirect overrides Stall.
  - Otherwise Stall → PC held.
  - Otherwise PC + 4, mod 2^32; 32'hFFFFFFFC wraps to 0.
- FetchCount increments on every RUN edge with InstrValid=1. It wraps mod 2^32.
- HALT:
  - PC and FetchCount frozen; InstrValid 0; Halted 1; MemAddr = PC; MemWrEn 0.
  - Only Reset leaves HALT.
- PCPlus4 = PC + 4 at all times, combinational.

## Timing

- The instruction memory read is combinational: the word at MemAddr is available in the same cycle InstrValid is high. Fetch latency is 0 cycles from the PC register.
- Redirect or Halt sampled at edge n takes effect in cycle n+1. There is no delay slot and no bubble inserted by this block.
- LoadReady, MemWrEn, MemAddr, InstrValid and Halted are combinational decodes of the registered state/counters plus same-cycle inputs. They must not glitch across the edge.
- LOAD→RUN: the first valid fetch (PC=RESET_PC) occurs in the cycle after the edge that sampled LoadDone or the final write.
- Reset asserted for one edge is sufficient. In the cycle after that edge, all outputs show their reset values.

## Test plan

- Load 4 words (0x20080005, 0x0C000004, 0x00000000, 0xFFFFFFFF) with LoadDone on the 4th:
  - MemWrEn pulses at addresses 0x0, 0x4, 0x8, 0xC.
  - The next cycle is RUN with PC=0x0 and InstrValid=1.
  - PC then reads 0x4, 0x8 on successive cycles.
- Redirect=1 with target 0x00000013 while Stall=1 at PC=0x8 → next PC=0x10, and FetchCount does not increment that cycle.
- Stall high for 3 cycles at PC=0x4 → PC stays 0x4 with InstrValid=0 for 3 cycles, then 0x8; FetchCount advances by exactly 1 afterward.
- Fill the memory with ADDR_W=2 (4 writes, no LoadDone) → auto-enter RUN after the 4th write; a 5th LoadValid is ignored and MemWrEn stays 0.
- Halt at PC=0xC:
  - Halted=1 and PC frozen at 0xC for 10 cycles; Redirect is ignored.
  - Reset then gives state LOAD, LoadReady=1, PC=RESET_PC and FetchCount=0.
- Reset mid-load after 2 writes → the next write targets address 0x0.
- PC=0xFFFFFFFC unstalled → next PC=0x00000000.
